fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that generates the Fetch-side inputs of the IF/ID pipeline register: `Instr_F`, `PC_F` and `PC_Plus_4_F`. It owns the program counter and runs a single-outstanding request/grant/response handshake with instruction memory. It honours the same `Stall_En` the IF/ID register sees and discards wrong-path fetches on a taken-branch/jump redirect. When no fetched instruction is available, it presents a NOP bubble, so IF/ID never captures stale data.

## Interface
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset
- CLK  in  1  clock; all state updates on posedge
- RST  in  1  reset, synchronous, active-high
- Stall_En  in  1  downstream stall (same signal as the IF/ID register); 1 = the presented instruction is not consumed
- Redirect_En  in  1  taken branch/jump from Execute; 1 = discard all wrong-path state and refetch
- Redirect_Target  in  32  new PC; bits [1:0] ignored (forced 2'b00)
- IMem_Req  out  1  fetch request
- IMem_Addr  out  32  word-aligned fetch address, valid while IMem_Req=1
- IMem_Gnt  in  1  memory accepts the request this cycle (meaningful only when IMem_Req=1)
- IMem_Rvalid  in  1  response data valid; minimum 1 cycle after grant, unbounded latency
- IMem_Rdata  in  32  instruction word
- Instr_F  out  32  instruction to IF/ID
- PC_F  out  32  address of Instr_F
- PC_Plus_4_F  out  32  PC_F + 4, mod 2^32
- Valid_F  out  1  1 = Instr_F is a real fetched instruction; 0 = bubble

## Operation
- State:
  - PC register `Next_PC`: address of the next request.
  - Request FSM.
  - One-entry holding slot: `Slot_Valid`, `Slot_Instr`, `Slot_PC`.
  - `Req_PC`: address of the outstanding request.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding; its response is kept.
  - DROP: one request outstanding; its response is discarded.
- `consume` = Slot_Valid & !Stall_En & !Redirect_En.
- `can_issue` = state==IDLE & (!Slot_Valid | consume).
- IMem_Req = can_issue & !Redirect_En & !RST. IMem_Addr = Next_PC.
- IDLE, IMem_Req & IMem_Gnt: go to WAIT. Req_PC <= Next_PC; Next_PC <= Next_PC + 4 (mod 2^32).
- WAIT, IMem_Rvalid:
  - Slot_Valid <= 1, Slot_Instr <= IMem_Rdata, Slot_PC <= Req_PC.
  - Go to IDLE.
- DROP, IMem_Rvalid: data discarded; go to IDLE.
- IMem_Rvalid in IDLE is a protocol violation and is ignored.
- Consume with no response arriving that cycle: Slot_Valid <= 0.
- Redirect_En=1 (priority over Stall_En and any consume/issue):
  - Next_PC <= {Redirect_Target[31:2], 2'b00}.
  - Slot_Valid <= 0.
  - WAIT goes to DROP; DROP stays DROP. If IMem_Rvalid arrives in the same cycle, the response is dropped and the FSM goes to IDLE.
- Output mux:
  - Slot_Valid=1: Instr_F = Slot_Instr, PC_F = Slot_PC, PC_Plus_4_F = Slot_PC + 4, Valid_F = 1.
  - Slot_Valid=0: Instr_F = 32'h0000_0013 (ADDI x0,x0,0), PC_F = PC_Plus_4_F = 32'h2A2A_2A2A, Valid_F = 0.
- Invariant: a response never arrives while the slot holds an unconsumed instruction, because issue requires the slot to be free or being consumed.
- Stall_En with an empty slot has no effect on fetching; the bubble is held by IF/ID regardless.

## Timing
- Reset (RST=1 at an edge):
  - Next_PC = RESET_PC, FSM = IDLE, Slot_Valid = 0.
  - Outputs are the bubble (0x13 / 0x2A2A_2A2A / 0x2A2A_2A2A, Valid_F = 0).
  - IMem_Req = 0 while RST=1.
- Reset mid-operation: an outstanding response arriving after reset deasserts is treated as an IDLE Rvalid and ignored. The memory must not return stale responses after reset.
- Best-case fetch, cycle-by-cycle:
  - Cycle n: request granted.
  - Cycle n+1: Rvalid.
  - Cycle n+2: instruction presented on Instr_F.
  - If consumed in n+2, the next request issues in the same cycle n+2.
  - Best-case throughput is therefore 1 instruction per 2 cycles.
- Redirect at cycle r:
  - IMem_Req = 0 in cycle r.
  - First target-path request in r+1, provided the FSM is IDLE then.
  - Otherwise the request issues the cycle after the dropped response arrives.
- PC arithmetic wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Test plan
- Reset release, RESET_PC=0x100, memory with 1-cycle latency returning addr^0xA5000000, no stalls -> IMem_Addr sequence 0x100, 0x104, 0x108; Instr_F/PC_F pairs appear every 2 cycles; bubble outputs in between.
- Stall_En held high for 5 cycles while the slot holds PC 0x104 -> Instr_F and PC_F stable, no new IMem_Req; stall release -> request 0x108 in the same cycle.
- Redirect_En with target 0x2003 while WAIT on 0x108 (response 3 cycles later) -> next cycle Valid_F=0, response for 0x108 never appears, next request address 0x2000.
- Redirect and IMem_Rvalid in the same cycle in WAIT -> data dropped; request 0x2000 issued the next cycle.
- Redirect to 0xFFFF_FFFC -> PC_Plus_4_F = 0x0000_0000; next request 0x0000_0000.
- Grant withheld for 4 cycles -> IMem_Req and IMem_Addr stable, Next_PC not advanced. RST pulsed mid-WAIT -> bubble outputs, first request at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs a single-outstanding req/gnt/rvalid
// handshake with instruction memory and feeds IF/ID through a one-entry slot.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Stall_En,
    input  logic        Redirect_En,
    input  logic [31:0] Redirect_Target,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic        IMem_Gnt,
    input  logic        IMem_Rvalid,
    input  logic [31:0] IMem_Rdata,
    output logic [31:0] Instr_F,
    output logic [31:0] PC_F,
    output logic [31:0] PC_Plus_4_F,
    output logic        Valid_F
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] BUBBLE_PC = 32'h2A2A_2A2A;

    fetch_state_t state_r;
    logic [31:0]  next_pc_r;
    logic [31:0]  req_pc_r;
    logic         slot_valid_r;
    logic [31:0]  slot_instr_r;
    logic [31:0]  slot_pc_r;

    logic consume_s;
    logic can_issue_s;
    logic issue_s;

    assign consume_s   = slot_valid_r & ~Stall_En & ~Redirect_En;
    assign can_issue_s = (state_r == ST_IDLE) & (~slot_valid_r | consume_s);
    assign IMem_Req    = can_issue_s & ~Redirect_En & ~RST;
    assign IMem_Addr   = next_pc_r;
    assign issue_s     = IMem_Req & IMem_Gnt;

    // PC, request FSM and holding slot
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= ST_IDLE;
            next_pc_r    <= RESET_PC;
            req_pc_r     <= RESET_PC;
            slot_valid_r <= 1'b0;
            slot_instr_r <= NOP_INSTR;
            slot_pc_r    <= BUBBLE_PC;
        end else if (Redirect_En) begin
            // Target low bits are forced to zero so fetches stay word aligned
            next_pc_r    <= Redirect_Target & 32'hFFFF_FFFC;
            slot_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: state_r <= ST_IDLE;
                ST_WAIT: state_r <= IMem_Rvalid ? ST_IDLE : ST_DROP;
                ST_DROP: state_r <= IMem_Rvalid ? ST_IDLE : ST_DROP;
                default: state_r <= ST_IDLE;
            endcase
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // A stray Rvalid here is a protocol violation and is ignored
                    if (consume_s) begin
                        slot_valid_r <= 1'b0;
                    end
                    if (issue_s) begin
                        state_r   <= ST_WAIT;
                        req_pc_r  <= next_pc_r;
                        next_pc_r <= next_pc_r + 32'd4;
                    end
                end
                ST_WAIT: begin
                    if (IMem_Rvalid) begin
                        state_r      <= ST_IDLE;
                        slot_valid_r <= 1'b1;
                        slot_instr_r <= IMem_Rdata;
                        slot_pc_r    <= req_pc_r;
                    end else if (consume_s) begin
                        slot_valid_r <= 1'b0;
                    end
                end
                ST_DROP: begin
                    if (IMem_Rvalid) begin
                        state_r <= ST_IDLE;
                    end
                    if (consume_s) begin
                        slot_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign Valid_F     = slot_valid_r;
    assign Instr_F     = slot_valid_r ? slot_instr_r : NOP_INSTR;
    assign PC_F        = slot_valid_r ? slot_pc_r : BUBBLE_PC;
    assign PC_Plus_4_F = slot_valid_r ? (slot_pc_r + 32'd4) : BUBBLE_PC;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: handshake, stall, redirect, PC wrap, reset.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall_en;
    logic        redirect_en;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] pc_plus_4_f;
    logic        valid_f;

    int check_cnt = 0;
    int err_cnt   = 0;

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .CLK             (clk),
        .RST             (rst),
        .Stall_En        (stall_en),
        .Redirect_En     (redirect_en),
        .Redirect_Target (redirect_target),
        .IMem_Req        (imem_req),
        .IMem_Addr       (imem_addr),
        .IMem_Gnt        (imem_gnt),
        .IMem_Rvalid     (imem_rvalid),
        .IMem_Rdata      (imem_rdata),
        .Instr_F         (instr_f),
        .PC_F            (pc_f),
        .PC_Plus_4_F     (pc_plus_4_f),
        .Valid_F         (valid_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bubble(input string tag);
        check_eq({tag, "_valid"}, {31'd0, valid_f}, 32'd0);
        check_eq({tag, "_instr"}, instr_f, 32'h0000_0013);
        check_eq({tag, "_pc"}, pc_f, 32'h2A2A_2A2A);
        check_eq({tag, "_pc4"}, pc_plus_4_f, 32'h2A2A_2A2A);
    endtask

    task automatic check_slot(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        check_eq({tag, "_valid"}, {31'd0, valid_f}, 32'd1);
        check_eq({tag, "_instr"}, instr_f, instr);
        check_eq({tag, "_pc"}, pc_f, pc);
        check_eq({tag, "_pc4"}, pc_plus_4_f, pc + 32'd4);
    endtask

    task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
        check_eq({tag, "_req"}, {31'd0, imem_req}, {31'd0, req});
        if (req) begin
            check_eq({tag, "_addr"}, imem_addr, addr);
        end
    endtask

    initial begin
        rst = 1'b1;
        stall_en = 1'b0;
        redirect_en = 1'b0;
        redirect_target = 32'd0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'd0;
        tick();
        tick();
        #1;
        check_bubble("rst");
        check_req("rst", 1'b0, 32'd0);

        // first fetch at RESET_PC
        rst = 1'b0;
        imem_gnt = 1'b1;
        #1;
        check_req("f0", 1'b1, 32'h0000_0100);
        tick();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hA500_0100;
        #1;
        check_req("f0_wait", 1'b0, 32'd0);
        check_bubble("f0_gap");
        tick();
        imem_rvalid = 1'b0;
        imem_gnt = 1'b1;
        #1;
        check_slot("f0_out", 32'h0000_0100, 32'hA500_0100);
        check_req("f1", 1'b1, 32'h0000_0104);
        tick();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hA500_0104;
        #1;
        check_bubble("f1_gap");
        tick();
        imem_rvalid = 1'b0;

        // stall holds the slot and blocks issue
        stall_en = 1'b1;
        #1;
        check_slot("stall0", 32'h0000_0104, 32'hA500_0104);
        check_req("stall0", 1'b0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_slot("stall", 32'h0000_0104, 32'hA500_0104);
            check_req("stall", 1'b0, 32'd0);
        end
        stall_en = 1'b0;
        imem_gnt = 1'b1;
        #1;
        check_req("unstall", 1'b1, 32'h0000_0108);
        tick();
        imem_gnt = 1'b0;

        // redirect while waiting on 0x108: response must be discarded
        redirect_en = 1'b1;
        redirect_target = 32'h0000_2003;
        #1;
        check_req("redir", 1'b0, 32'd0);
        tick();
        redirect_en = 1'b0;
        #1;
        check_bubble("drop0");
        check_req("drop0", 1'b0, 32'd0);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata = 32'hA500_0108;
        #1;
        check_req("drop1", 1'b0, 32'd0);
        tick();
        imem_rvalid = 1'b0;
        #1;
        check_bubble("dropped");
        check_req("tgt", 1'b1, 32'h0000_2000);

        // grant withheld: request and address must hold
        for (int i = 0; i < 4; i++) begin
            tick();
            check_req("nognt", 1'b1, 32'h0000_2000);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;

        // redirect coinciding with the response in WAIT
        redirect_en = 1'b1;
        redirect_target = 32'h0000_2000;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        redirect_en = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        check_bubble("coinc");
        check_req("coinc", 1'b1, 32'h0000_2000);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hA500_2000;
        tick();
        imem_rvalid = 1'b0;
        #1;
        check_slot("t0_out", 32'h0000_2000, 32'hA500_2000);
        check_req("t1", 1'b1, 32'h0000_2004);

        // redirect to the top of memory: low bits ignored, PC wraps
        redirect_en = 1'b1;
        redirect_target = 32'hFFFF_FFFF;
        #1;
        check_req("redir_top", 1'b0, 32'd0);
        tick();
        redirect_en = 1'b0;
        #1;
        check_bubble("top_gap");
        check_req("top", 1'b1, 32'hFFFF_FFFC);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h5AFF_FFFC;
        tick();
        imem_rvalid = 1'b0;
        stall_en = 1'b1;
        #1;
        check_slot("top_out", 32'hFFFF_FFFC, 32'h5AFF_FFFC);
        check_eq("wrap_pc4", pc_plus_4_f, 32'h0000_0000);
        stall_en = 1'b0;
        imem_gnt = 1'b1;
        #1;
        check_req("wrap", 1'b1, 32'h0000_0000);
        tick();
        imem_gnt = 1'b0;

        // reset in the middle of WAIT, then a stale response is ignored
        rst = 1'b1;
        #1;
        check_req("rst_mid", 1'b0, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check_bubble("rst_mid");
        check_req("rst_mid_req", 1'b1, 32'h0000_0100);
        imem_rvalid = 1'b1;
        imem_rdata = 32'h1234_5678;
        tick();
        imem_rvalid = 1'b0;
        #1;
        check_bubble("stale");
        check_req("stale", 1'b1, 32'h0000_0100);

        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end

endmodule
